// File: rtl/line_buf_ctrl.sv
// ---------------------------------------------------------------------------
// line_buf_ctrl
// Sequencer for the two-RAM line buffer (RAM A / RAM B, 11-bit addresses).
// Converts the raw pixel-valid stream into read/write strobes and addresses
// so that the two RAMs rotate as the row-1 / row-2 line stores. It also
// provides the delayed tap strobe/column and the 3x3 window-valid flag.
//
// Every pixel is read at cycle t+1 and written back at cycle t+2. The
// buffer registers its shared write data for one cycle, so each column is
// always read before it is overwritten.
//
// Optional build macro: LBC_LINE_STATS_EN adds the line_width / width_err
// outputs.
// ---------------------------------------------------------------------------
module line_buf_ctrl #(
    parameter int MAX_COL = 2047,
    parameter int RD_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic        pix_valid,
    output logic        rama_wren,
    output logic        rama_rden,
    output logic        ramb_wren,
    output logic        ramb_rden,
    output logic [10:0] rama_wradd,
    output logic [10:0] rama_rdadd,
    output logic [10:0] ramb_wradd,
    output logic [10:0] ramb_rdadd,
    output logic        row1_sel,
    output logic        tap_valid,
    output logic [10:0] tap_col,
    output logic        win_valid,
    output logic [1:0]  line_cnt,
    output logic        col_ovf
`ifdef LBC_LINE_STATS_EN
    ,
    output logic [10:0] line_width,
    output logic        width_err
`endif
);

    localparam logic [10:0] MAX_C = 11'(MAX_COL);
    localparam int          LAST  = RD_LAT - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINE   = 2'd1,
        ST_HBLANK = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    // Line-level state
    logic        pv_d_r;     // a pixel was accepted last cycle
    logic [10:0] col_r;      // column of the next pixel
    logic        sat_r;      // a pixel has already used column MAX_COL
    logic        sel_r;
    logic [1:0]  lcnt_r;
    logic        ovf_r;

    // Current-cycle decode (sof already folded in)
    logic        active_s;
    logic        pix_s;
    logic        eol_s;
    logic        ovf_pix_s;
    logic        win_ok_s;
    logic [10:0] cur_col_s;
    logic        cur_sat_s;
    logic        cur_sel_s;
    logic [1:0]  cur_lcnt_s;
    logic [10:0] col_nx_s;
    logic        sat_nx_s;
    logic        sel_nx_s;
    logic [1:0]  lcnt_nx_s;
    logic        ovf_nx_s;

    // Write stage: matches the buffer's one-cycle data register
    logic        wr_v_r;
    logic [10:0] wr_a_r;
    logic        wr_b_r;

    // Tap delay line (valid, column, row-2-present)
    logic        tv_p_r [RD_LAT];
    logic [10:0] tc_p_r [RD_LAT];
    logic        tk_p_r [RD_LAT];

    // Output registers
    logic        rama_wren_r;
    logic        rama_rden_r;
    logic        ramb_wren_r;
    logic        ramb_rden_r;
    logic [10:0] rama_wradd_r;
    logic [10:0] rama_rdadd_r;
    logic [10:0] ramb_wradd_r;
    logic [10:0] ramb_rdadd_r;
    logic        tap_valid_r;
    logic [10:0] tap_col_r;
    logic        win_valid_r;

    // FSM next-state: sof restarts the frame from any state
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sof) begin
                    state_s = ST_LINE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LINE: begin
                if (sof) begin
                    state_s = ST_LINE;
                end else if (pv_d_r && !pix_valid) begin
                    state_s = ST_HBLANK;
                end else begin
                    state_s = ST_LINE;
                end
            end
            ST_HBLANK: begin
                if (sof || pix_valid) begin
                    state_s = ST_LINE;
                end else begin
                    state_s = ST_HBLANK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Per-cycle decode; sof overrides the line state before the pixel is used
    always_comb begin
        active_s   = (state_r != ST_IDLE);
        pix_s      = pix_valid & (sof | active_s);
        eol_s      = ~sof & active_s & pv_d_r & ~pix_valid;
        cur_col_s  = 11'd0;
        cur_sat_s  = 1'b0;
        cur_sel_s  = 1'b0;
        cur_lcnt_s = 2'd0;
        ovf_nx_s   = 1'b0;
        if (sof) begin
            cur_col_s  = 11'd0;
            cur_sat_s  = 1'b0;
            cur_sel_s  = 1'b0;
            cur_lcnt_s = 2'd0;
            ovf_nx_s   = 1'b0;
        end else begin
            cur_col_s  = col_r;
            cur_sat_s  = sat_r;
            cur_sel_s  = sel_r;
            cur_lcnt_s = lcnt_r;
            ovf_nx_s   = ovf_r;
        end
        ovf_pix_s = pix_s & cur_sat_s;
        ovf_nx_s  = ovf_nx_s | ovf_pix_s;
        win_ok_s  = (cur_lcnt_s >= 2'd2);
    end

    // Next column / line bookkeeping
    always_comb begin
        col_nx_s  = cur_col_s;
        sat_nx_s  = cur_sat_s;
        sel_nx_s  = cur_sel_s;
        lcnt_nx_s = cur_lcnt_s;
        if (pix_s) begin
            if (cur_col_s == MAX_C) begin
                col_nx_s = MAX_C;
                sat_nx_s = 1'b1;
            end else begin
                col_nx_s = cur_col_s + 11'd1;
                sat_nx_s = cur_sat_s;
            end
        end else if (eol_s) begin
            col_nx_s = 11'd0;
            sat_nx_s = 1'b0;
            sel_nx_s = ~cur_sel_s;
            if (cur_lcnt_s == 2'd3) begin
                lcnt_nx_s = 2'd3;
            end else begin
                lcnt_nx_s = cur_lcnt_s + 2'd1;
            end
        end else begin
            col_nx_s = cur_col_s;
        end
    end

    // Line state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_d_r <= 1'b0;
            col_r  <= 11'd0;
            sat_r  <= 1'b0;
            sel_r  <= 1'b0;
            lcnt_r <= 2'd0;
            ovf_r  <= 1'b0;
        end else begin
            pv_d_r <= pix_s;
            col_r  <= col_nx_s;
            sat_r  <= sat_nx_s;
            sel_r  <= sel_nx_s;
            lcnt_r <= lcnt_nx_s;
            ovf_r  <= ovf_nx_s;
        end
    end

    // Read strobes: both RAMs read the current column of every pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rama_rden_r  <= 1'b0;
            ramb_rden_r  <= 1'b0;
            rama_rdadd_r <= 11'd0;
            ramb_rdadd_r <= 11'd0;
        end else begin
            rama_rden_r <= pix_s;
            ramb_rden_r <= pix_s;
            if (pix_s) begin
                rama_rdadd_r <= cur_col_s;
                ramb_rdadd_r <= cur_col_s;
            end
        end
    end

    // Write stage: capture column and target RAM (the row-2 store) at read time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_v_r <= 1'b0;
            wr_a_r <= 11'd0;
            wr_b_r <= 1'b0;
        end else begin
            wr_v_r <= pix_s & ~ovf_pix_s;
            wr_a_r <= cur_col_s;
            wr_b_r <= ~cur_sel_s;
        end
    end

    // Write strobes, one cycle after the matching read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rama_wren_r  <= 1'b0;
            ramb_wren_r  <= 1'b0;
            rama_wradd_r <= 11'd0;
            ramb_wradd_r <= 11'd0;
        end else begin
            rama_wren_r <= wr_v_r & ~wr_b_r;
            ramb_wren_r <= wr_v_r & wr_b_r;
            if (wr_v_r && !wr_b_r) begin
                rama_wradd_r <= wr_a_r;
            end
            if (wr_v_r && wr_b_r) begin
                ramb_wradd_r <= wr_a_r;
            end
        end
    end

    // Tap delay line; sof discards everything older than its own pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tv_p_r[i] <= 1'b0;
                tc_p_r[i] <= 11'd0;
                tk_p_r[i] <= 1'b0;
            end
        end else begin
            tv_p_r[0] <= pix_s;
            tc_p_r[0] <= cur_col_s;
            tk_p_r[0] <= win_ok_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tv_p_r[i] <= tv_p_r[i-1] & ~sof;
                tc_p_r[i] <= tc_p_r[i-1];
                tk_p_r[i] <= tk_p_r[i-1];
            end
        end
    end

    // Tap outputs: aligned with RAM q, RD_LAT cycles after the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_valid_r <= 1'b0;
            tap_col_r   <= 11'd0;
            win_valid_r <= 1'b0;
        end else begin
            tap_valid_r <= tv_p_r[LAST] & ~sof;
            tap_col_r   <= tc_p_r[LAST];
            win_valid_r <= tv_p_r[LAST] & ~sof & tk_p_r[LAST] &
                           (tc_p_r[LAST] >= 11'd2);
        end
    end

`ifdef LBC_LINE_STATS_EN
    logic [10:0] lw_r;
    logic        werr_r;
    logic        have_prev_r;

    // Line width latch and width-change pulse (first line after sof exempt)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lw_r        <= 11'd0;
            werr_r      <= 1'b0;
            have_prev_r <= 1'b0;
        end else if (sof) begin
            werr_r      <= 1'b0;
            have_prev_r <= 1'b0;
        end else if (eol_s) begin
            lw_r        <= col_r;
            werr_r      <= have_prev_r & (col_r != lw_r);
            have_prev_r <= 1'b1;
        end else begin
            werr_r      <= 1'b0;
        end
    end

    assign line_width = lw_r;
    assign width_err  = werr_r;
`endif

    assign rama_wren  = rama_wren_r;
    assign rama_rden  = rama_rden_r;
    assign ramb_wren  = ramb_wren_r;
    assign ramb_rden  = ramb_rden_r;
    assign rama_wradd = rama_wradd_r;
    assign rama_rdadd = rama_rdadd_r;
    assign ramb_wradd = ramb_wradd_r;
    assign ramb_rdadd = ramb_rdadd_r;
    assign row1_sel   = sel_r;
    assign line_cnt   = lcnt_r;
    assign col_ovf    = ovf_r;
    assign tap_valid  = tap_valid_r;
    assign tap_col    = tap_col_r;
    assign win_valid  = win_valid_r;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buf_ctrl
// Directed and random stimulus for line_buf_ctrl. A frame-level model
// (pixel index within the line, lines completed, sticky overflow) schedules
// the expected value of every output for every cycle. Each cycle is then
// compared against that schedule on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_line_buf_ctrl;

    localparam int MAX_COL = 2047;
    localparam int RD_LAT  = 2;
    localparam int NC      = 8192;

    logic        clk;
    logic        rst_n;
    logic        sof;
    logic        pix_valid;
    logic        rama_wren, rama_rden, ramb_wren, ramb_rden;
    logic [10:0] rama_wradd, rama_rdadd, ramb_wradd, ramb_rdadd;
    logic        row1_sel, tap_valid, win_valid, col_ovf;
    logic [10:0] tap_col;
    logic [1:0]  line_cnt;
`ifdef LBC_LINE_STATS_EN
    logic [10:0] line_width;
    logic        width_err;
`endif

    line_buf_ctrl #(.MAX_COL(MAX_COL), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .rama_wren  (rama_wren),
        .rama_rden  (rama_rden),
        .ramb_wren  (ramb_wren),
        .ramb_rden  (ramb_rden),
        .rama_wradd (rama_wradd),
        .rama_rdadd (rama_rdadd),
        .ramb_wradd (ramb_wradd),
        .ramb_rdadd (ramb_rdadd),
        .row1_sel   (row1_sel),
        .tap_valid  (tap_valid),
        .tap_col    (tap_col),
        .win_valid  (win_valid),
        .line_cnt   (line_cnt),
        .col_ovf    (col_ovf)
`ifdef LBC_LINE_STATS_EN
        ,
        .line_width (line_width),
        .width_err  (width_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Expected outputs, indexed by the cycle in which they are visible
    bit        e_rd  [NC];
    bit        e_awr [NC];
    bit        e_bwr [NC];
    bit        e_sel [NC];
    bit        e_tv  [NC];
    bit        e_win [NC];
    bit        e_ovf [NC];
    bit [10:0] e_rda [NC];
    bit [10:0] e_wa  [NC];
    bit [10:0] e_tc  [NC];
    bit [1:0]  e_lc  [NC];
`ifdef LBC_LINE_STATS_EN
    bit [10:0] e_lw  [NC];
    bit        e_we  [NC];
    bit        m_have;
    int        m_width;
`endif

    // Frame-level model state
    bit m_active;   // a sof has been seen since reset
    bit m_prev;     // previous cycle carried an accepted pixel
    bit m_ovf;
    int m_pix;      // pixels accepted so far in this line (unsaturated)
    int m_line;     // lines completed since sof (unsaturated)

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_cycle();
        int c;
        c = cyc;
        chk("ctrl",
            64'({rama_rden, ramb_rden, rama_wren, ramb_wren, row1_sel,
                 tap_valid, win_valid, line_cnt, col_ovf}),
            64'({e_rd[c], e_rd[c], e_awr[c], e_bwr[c], e_sel[c],
                 e_tv[c], e_win[c], e_lc[c], e_ovf[c]}));
        if (e_rd[c])  chk("rdadd", 64'({rama_rdadd, ramb_rdadd}), 64'({e_rda[c], e_rda[c]}));
        if (e_awr[c]) chk("rama_wradd", 64'(rama_wradd), 64'(e_wa[c]));
        if (e_bwr[c]) chk("ramb_wradd", 64'(ramb_wradd), 64'(e_wa[c]));
        if (e_tv[c])  chk("tap_col", 64'(tap_col), 64'(e_tc[c]));
`ifdef LBC_LINE_STATS_EN
        chk("stats", 64'({line_width, width_err}), 64'({e_lw[c], e_we[c]}));
`endif
    endtask

    // Apply the inputs of cycle t to the model and schedule their effects
    task automatic apply(input bit s, input bit p);
        int  t;
        int  col;
        bit  was_active;
        bit  pixel;
        bit  eol;
        t          = cyc;
        was_active = m_active;
        eol        = !s && was_active && m_prev && !p;
        if (s) begin
            m_active = 1'b1;
            m_pix    = 0;
            m_line   = 0;
            m_ovf    = 1'b0;
`ifdef LBC_LINE_STATS_EN
            m_have   = 1'b0;
`endif
            for (int i = 1; i <= RD_LAT; i++) begin
                e_tv[t+i]  = 1'b0;
                e_win[t+i] = 1'b0;
            end
        end
        pixel = p && m_active;
        if (pixel) begin
            col = (m_pix > MAX_COL) ? MAX_COL : m_pix;
            e_rd[t+1]  = 1'b1;
            e_rda[t+1] = 11'(col);
            if (m_pix <= MAX_COL) begin
                if (m_line % 2 == 0) e_bwr[t+2] = 1'b1;
                else                 e_awr[t+2] = 1'b1;
                e_wa[t+2] = 11'(col);
            end else begin
                m_ovf = 1'b1;
            end
            e_tv[t+RD_LAT+1]  = 1'b1;
            e_tc[t+RD_LAT+1]  = 11'(col);
            e_win[t+RD_LAT+1] = (m_line >= 2) && (col >= 2);
            m_pix++;
        end
        if (eol) begin
`ifdef LBC_LINE_STATS_EN
            begin
                int w;
                w = (m_pix > MAX_COL) ? MAX_COL : m_pix;
                e_we[t+1] = m_have && (w != m_width);
                m_width   = w;
                m_have    = 1'b1;
            end
`endif
            m_line++;
            m_pix = 0;
        end
        m_prev     = pixel;
        e_sel[t+1] = (m_line % 2) != 0;
        e_lc[t+1]  = (m_line > 3) ? 2'd3 : 2'(m_line);
        e_ovf[t+1] = m_ovf;
`ifdef LBC_LINE_STATS_EN
        e_lw[t+1]  = 11'(m_width);
`endif
    endtask

    task automatic step(input bit s, input bit p);
        @(negedge clk);
        check_cycle();
        rst_n     = 1'b1;
        sof       = s;
        pix_valid = p;
        apply(s, p);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_cycle();
        rst_n = 1'b0;
        sof   = 1'b0;
        #1;
        chk("reset_ctrl",
            64'({rama_rden, ramb_rden, rama_wren, ramb_wren, row1_sel,
                 tap_valid, win_valid, line_cnt, col_ovf, tap_col}), 64'd0);
        chk("reset_addr", 64'({rama_wradd, rama_rdadd, ramb_wradd, ramb_rdadd}), 64'd0);
`ifdef LBC_LINE_STATS_EN
        chk("reset_stats", 64'({line_width, width_err}), 64'd0);
        m_have  = 1'b0;
        m_width = 0;
        for (int i = cyc + 1; i < NC; i++) begin
            e_lw[i] = 11'd0;
            e_we[i] = 1'b0;
        end
`endif
        for (int i = cyc + 1; i < NC; i++) begin
            e_rd[i] = 1'b0;  e_awr[i] = 1'b0; e_bwr[i] = 1'b0; e_sel[i] = 1'b0;
            e_tv[i] = 1'b0;  e_win[i] = 1'b0; e_ovf[i] = 1'b0; e_lc[i]  = 2'd0;
        end
        m_active = 1'b0;
        m_prev   = 1'b0;
        m_ovf    = 1'b0;
        m_pix    = 0;
        m_line   = 0;
        cyc++;
    endtask

    task automatic run_line(input int n, input int blank);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
        for (int i = 0; i < blank; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        bit pv_r;
        pv_r      = 1'b0;
        rst_n     = 1'b0;
        sof       = 1'b0;
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("por_ctrl",
            64'({rama_rden, ramb_rden, rama_wren, ramb_wren, row1_sel,
                 tap_valid, win_valid, line_cnt, col_ovf, tap_col}), 64'd0);
        chk("por_addr", 64'({rama_wradd, rama_rdadd, ramb_wradd, ramb_rdadd}), 64'd0);

        // pix_valid before any sof is ignored
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Three lines of 8 pixels, 4-cycle blanking
        step(1'b1, 1'b0);
        for (int l = 0; l < 3; l++) run_line(8, 4);

        // Over-long line: 2050 pixels, then sof clears the overflow flag
        step(1'b1, 1'b0);
        run_line(2050, 4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // sof coincident with a pixel in the middle of line 1
        run_line(5, 2);
        run_line(3, 0);
        step(1'b1, 1'b1);
        run_line(4, 3);

        // Single-cycle blanking is a line break
        run_line(4, 1);
        run_line(4, 3);

        // Reset for one cycle in the middle of a line
        step(1'b1, 1'b0);
        run_line(5, 0);
        do_reset();
        run_line(5, 1);
        step(1'b1, 1'b0);
        run_line(4, 4);

        // Widths 8, 8, 6
        step(1'b1, 1'b0);
        run_line(8, 3);
        run_line(8, 3);
        run_line(6, 3);

        // Random pixel/blanking pattern with occasional sof and one reset
        step(1'b1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            if ($urandom_range(0, 3) == 0) pv_r = ~pv_r;
            step($urandom_range(0, 79) == 0, pv_r);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
- Sequencer for the two-RAM line buffer (RAM A / RAM B, 10-bit data, 11-bit addresses, shared data input registered once inside the buffer).
- Takes the raw CCD pixel-valid stream and generates every wren/rden/address for both RAMs.
- RAMs rotate as row-1/row-2 line stores, so the downstream 3x3 edge kernel gets live row, row-1 and row-2 column-aligned.
- Also flags when a full 3x3 window is valid.

Parameters:
- MAX_COL, 2047: last legal column index; column counter saturates here.
- RD_LAT, 2: cycles from rden/rdaddress to RAM q valid; must be 1..4.

Ports:
- clk  in  1  pixel clock, shared with line buffer
- rst_n  in  1  asynchronous active-low reset
- sof  in  1  start-of-frame pulse, one cycle
- pix_valid  in  1  pixel valid; high for each active pixel of a line, low in blanking
- rama_wren  out  1  RAM A write enable
- rama_rden  out  1  RAM A read enable
- ramb_wren  out  1  RAM B write enable
- ramb_rden  out  1  RAM B read enable
- rama_wradd  out  11  RAM A write address
- rama_rdadd  out  11  RAM A read address
- ramb_wradd  out  11  RAM B write address
- ramb_rdadd  out  11  RAM B read address
- row1_sel  out  1  0: RAM A holds row-1 and RAM B holds row-2; 1: swapped
- tap_valid  out  1  RAM q outputs valid for tap_col
- tap_col  out  11  column of current tap outputs
- win_valid  out  1  tap_valid and line_cnt>=2 and tap_col>=2
- line_cnt  out  2  lines completed this frame; saturates at 3
- col_ovf  out  1  sticky: a line exceeded MAX_COL+1 pixels; cleared by sof

Behaviour:
- Reset: every output 0; FSM in IDLE. Assertion mid-line aborts immediately, with no pending write.
- FSM states:
  - IDLE: pix_valid ignored. sof -> LINE.
  - LINE: pix_valid high counts pixels. Falling edge of pix_valid -> HBLANK.
  - HBLANK: pix_valid rising -> LINE. sof -> LINE.
- sof in any state:
  - col=0, line_cnt=0, row1_sel=0, col_ovf=0.
  - Pipelines flushed; pending write completes.
  - sof wins over pix_valid in the same cycle: that pixel becomes column 0 of line 0.
- Read, cycle t (pix_valid=1 in LINE, col=c):
  - rama_rden=ramb_rden=1; both rdadd=c.
  - Registered outputs, so the pins show these at t+1.
- Write, t+1, matching the buffer's one-cycle data register:
  - wren is asserted only on the RAM holding row-2 (the row1_sel value sampled at t); wradd=c.
  - The read of c always precedes the write of c by one cycle, giving read-old-data by construction.
- Column counter:
  - c increments per valid pixel and saturates at MAX_COL.
  - A further valid pixel at MAX_COL sets col_ovf and suppresses wren for that pixel.
- End of line (pix_valid 1->0):
  - Toggle row1_sel, line_cnt+1 (saturating at 3), col=0.
  - The last pixel's write uses the pre-toggle select.
- tap_valid/tap_col: pix_valid and c delayed RD_LAT+1 cycles.
- Single-cycle blanking: a pix_valid 1,0,1 pattern is a legal line break.
- No rden while pix_valid is low.

Optional Feature:
- Macro LBC_LINE_STATS_EN.
- When defined, adds outputs:
  - line_width[10:0]: pixel count of the last completed line, latched at end of line; reset 0.
  - width_err: one-cycle pulse at end of line when the width differs from the previous line's width, excluding the first line after sof.
- When undefined, neither port exists and no logic is added.

Test Plan:
- Reset, then sof, then 3 lines of 8 pixels with 4-cycle blanking:
  - line 0 writes RAM B addresses 0..7.
  - line 1 writes RAM A addresses 0..7.
  - win_valid first high with tap_col=2 on line 2.
  - row1_sel sequence 0,1,0.
- Check wren/wradd on every pixel: wren on the RAM opposite row1_sel, exactly one cycle after the matching rden/rdadd of the same address.
- Line of 2050 pixels: col holds at 2047, col_ovf=1 from the pixel after 2047, no wren on overflow pixels; next sof clears col_ovf.
- sof coincident with pix_valid mid-line 1: col restarts at 0, line_cnt=0, row1_sel=0, and the in-flight pixel is written at address 0.
- rst_n low for 1 cycle mid-line: all outputs 0 asynchronously; no write after release until sof followed by pix_valid.
- With LBC_LINE_STATS_EN: lines of 8, 8, 6 -> line_width 8, 8, 6; a single width_err pulse after the third line.
